// File: rtl/output_fifo_pkg.sv
// Shared constants for the output FIFO bridge: CSR word map, status/event bit
// positions and the status-vector helper used by the top and its reset logic.
package output_fifo_pkg;

    localparam int CSR_W  = 32;
    localparam int NUM_ST = 4;

    typedef enum logic [2:0] {
        CSR_LEVEL   = 3'd0,
        CSR_STATUS  = 3'd1,
        CSR_EVENT   = 3'd2,
        CSR_IENABLE = 3'd3,
        CSR_AF      = 3'd4,
        CSR_AE      = 3'd5,
        CSR_WRITES  = 3'd6,
        CSR_STALLS  = 3'd7
    } csr_addr_e;

    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_AFULL  = 2;
    localparam int ST_AEMPTY = 3;

    function automatic logic [NUM_ST-1:0] calcStatus(input int level, input int af,
                                                     input int ae, input int depth);
        logic [NUM_ST-1:0] s;
        s            = '0;
        s[ST_FULL]   = (level == depth);
        s[ST_EMPTY]  = (level == 0);
        s[ST_AFULL]  = (level >= af);
        s[ST_AEMPTY] = (level <= ae);
        return s;
    endfunction

endpackage

// File: rtl/output_fifo_mem.sv
// Dual-port FIFO storage with wrapping read/write pointers, fill level and
// full/empty flags. The caller only pushes when not full and pops when not empty.
module output_fifo_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [LVL_W-1:0]  level_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0]  level_q, level_d;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        level_d = level_q;
        if (push_i) wrPtr_d = wrPtr_q + 1'b1;
        if (pop_i)  rdPtr_d = rdPtr_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
        end
    end

    // Storage is not reset; stale contents are hidden by masking the head while empty.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wrPtr_q] <= wdata_i;
    end

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign rdata_o = empty_o ? '0 : mem_q[rdPtr_q];
    assign level_o = level_q;

endmodule

// File: rtl/output_fifo_io.sv
// Avalon-MM write slave to Avalon-ST source FIFO bridge with CSRs, sticky W1C events and IRQ.
// Define OUTPUT_FIFO_STATS_EN to add accepted-write and stall counters at CSR 6/7.
module output_fifo_io
    import output_fifo_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int AF_INIT = DEPTH - 2,
    parameter int AE_INIT = 1,
    parameter int LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [DATA_W-1:0] fifo_in_writedata,
    input  logic              fifo_in_write,
    output logic              fifo_in_waitrequest,
    input  logic [2:0]        fifo_in_csr_address,
    input  logic              fifo_in_csr_read,
    input  logic [CSR_W-1:0]  fifo_in_csr_writedata,
    input  logic              fifo_in_csr_write,
    output logic [CSR_W-1:0]  fifo_in_csr_readdata,
    output logic [DATA_W-1:0] fifo_out_data,
    output logic              fifo_out_valid,
    input  logic              fifo_out_ready,
    output logic              fifo_irq
);
    // Status at reset, so no edge is seen on the first cycle out of reset.
    localparam logic [NUM_ST-1:0] STATUS_RST = calcStatus(0, AF_INIT, AE_INIT, DEPTH);

    logic [LVL_W-1:0]  level;
    logic              full, empty, push, pop;
    logic [NUM_ST-1:0] status, statusPrev_q, event_q, event_d, evtClr;
    logic [NUM_ST-1:0] ienable_q, ienable_d;
    logic [LVL_W-1:0]  af_q, af_d, ae_q, ae_d;
    logic              irq_q;
    logic [CSR_W-1:0]  rdata_q, rdata_d;
    csr_addr_e         csrAddr;
    logic              unusedCsrBits;

    assign csrAddr       = csr_addr_e'(fifo_in_csr_address);
    assign unusedCsrBits = ^fifo_in_csr_writedata[CSR_W-1:LVL_W];

    assign push = fifo_in_write && !full;
    assign pop  = !empty && fifo_out_ready;

    output_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LVL_W  (LVL_W)
    ) u_mem (
        .clk_i   (clk_clk),
        .rst_i   (reset_reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (fifo_in_writedata),
        .rdata_o (fifo_out_data),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    assign status = calcStatus(int'(level), int'(af_q), int'(ae_q), DEPTH);

`ifdef OUTPUT_FIFO_STATS_EN
    logic [CSR_W-1:0] writes_q, stalls_q;
    logic             clrWrites, clrStalls, stall;

    assign clrWrites = fifo_in_csr_write && (csrAddr == CSR_WRITES);
    assign clrStalls = fifo_in_csr_write && (csrAddr == CSR_STALLS);
    assign stall     = fifo_in_write && full;

    // Saturating counters; a CSR write clears and overrides a same-cycle increment.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            writes_q <= '0;
            stalls_q <= '0;
        end else begin
            if (clrWrites)                    writes_q <= '0;
            else if (push && writes_q != '1)  writes_q <= writes_q + 1'b1;
            if (clrStalls)                    stalls_q <= '0;
            else if (stall && stalls_q != '1) stalls_q <= stalls_q + 1'b1;
        end
    end
`endif

    always_comb begin
        ienable_d = ienable_q;
        af_d      = af_q;
        ae_d      = ae_q;
        evtClr    = '0;
        if (fifo_in_csr_write) begin
            case (csrAddr)
                CSR_EVENT:   evtClr    = fifo_in_csr_writedata[NUM_ST-1:0];
                CSR_IENABLE: ienable_d = fifo_in_csr_writedata[NUM_ST-1:0];
                CSR_AF:      af_d      = fifo_in_csr_writedata[LVL_W-1:0];
                CSR_AE:      ae_d      = fifo_in_csr_writedata[LVL_W-1:0];
                default:     evtClr    = '0;
            endcase
        end
        // Rising status edges set events after the clear is applied, so set wins.
        event_d = (event_q & ~evtClr) | (status & ~statusPrev_q);
    end

    always_comb begin
        rdata_d = '0;
        if (fifo_in_csr_read) begin
            case (csrAddr)
                CSR_LEVEL:   rdata_d = CSR_W'(level);
                CSR_STATUS:  rdata_d = CSR_W'(status);
                CSR_EVENT:   rdata_d = CSR_W'(event_q);
                CSR_IENABLE: rdata_d = CSR_W'(ienable_q);
                CSR_AF:      rdata_d = CSR_W'(af_q);
                CSR_AE:      rdata_d = CSR_W'(ae_q);
`ifdef OUTPUT_FIFO_STATS_EN
                CSR_WRITES:  rdata_d = writes_q;
                CSR_STALLS:  rdata_d = stalls_q;
`endif
                default:     rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            statusPrev_q <= STATUS_RST;
            event_q      <= '0;
            ienable_q    <= '0;
            af_q         <= LVL_W'(AF_INIT);
            ae_q         <= LVL_W'(AE_INIT);
            irq_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            statusPrev_q <= status;
            event_q      <= event_d;
            ienable_q    <= ienable_d;
            af_q         <= af_d;
            ae_q         <= ae_d;
            irq_q        <= |(event_d & ienable_d);
            rdata_q      <= rdata_d;
        end
    end

    assign fifo_in_waitrequest  = full;
    assign fifo_out_valid       = !empty;
    assign fifo_irq             = irq_q;
    assign fifo_in_csr_readdata = rdata_q;

endmodule

// File: tb/tb_output_fifo_io.sv
// Bench for output_fifo_io: directed vectors; expected stream words and CSR read
// values are queued at issue time and checked by a monitor on the falling edge.
module tb_output_fifo_io;
    import output_fifo_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;

    logic              clock;
    logic              reset;
    logic [DATA_W-1:0] fifoWdata;
    logic              fifoWrite;
    logic              waitrequest;
    logic [2:0]        csrAddr;
    logic              csrRead;
    logic [31:0]       csrWdata;
    logic              csrWrite;
    logic [31:0]       csrReaddata;
    logic [DATA_W-1:0] fifoData;
    logic              fifoValid;
    logic              fifoReady;
    logic              irq;

    int          checksTotal  = 0;
    int          checksPassed = 0;
    logic [31:0] expDataQ[$];
    logic [31:0] csrExpQ[$];
    logic [2:0]  csrAddrQ[$];
    logic        csrPending   = 1'b0;

    output_fifo_io #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_clk               (clock),
        .reset_reset           (reset),
        .fifo_in_writedata     (fifoWdata),
        .fifo_in_write         (fifoWrite),
        .fifo_in_waitrequest   (waitrequest),
        .fifo_in_csr_address   (csrAddr),
        .fifo_in_csr_read      (csrRead),
        .fifo_in_csr_writedata (csrWdata),
        .fifo_in_csr_write     (csrWrite),
        .fifo_in_csr_readdata  (csrReaddata),
        .fifo_out_data         (fifoData),
        .fifo_out_valid        (fifoValid),
        .fifo_out_ready        (fifoReady),
        .fifo_irq              (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Drives every bus input for one clock, then drops the strobes.
    task automatic applyStimulus(input logic wr, input logic [31:0] wdata, input logic rd,
                                 input logic cwr, input logic [2:0] addr, input logic [31:0] cdata);
        fifoWrite = wr;
        fifoWdata = wdata;
        csrRead   = rd;
        csrWrite  = cwr;
        csrAddr   = addr;
        csrWdata  = cdata;
        @(posedge clock); #1;
        fifoWrite = 1'b0;
        csrRead   = 1'b0;
        csrWrite  = 1'b0;
    endtask

    task automatic pushWord(input logic [31:0] data);
        expDataQ.push_back(data);
        applyStimulus(1'b1, data, 1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic readCsr(input logic [2:0] addr, input logic [31:0] expected);
        csrAddrQ.push_back(addr);
        csrExpQ.push_back(expected);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, addr, 32'd0);
    endtask

    task automatic writeCsr(input logic [2:0] addr, input logic [31:0] data);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, addr, data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic waitEmpty(input int budget);
        int n = 0;
        while (fifoValid && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        if (fifoValid) begin
            checksTotal++;
            $display("[TB] FAIL drain_timeout: still valid after %0d cycles, expected empty", budget);
        end
    endtask

    // Monitor: stream handshakes and CSR read returns are checked against the queues.
    always @(negedge clock) begin
        logic [31:0] exp;
        logic [2:0]  a;
        if (fifoValid && fifoReady) begin
            if (expDataQ.size() == 0) begin
                checksTotal++;
                $display("[TB] FAIL stream_unexpected: got word 0x%0h, expected none", fifoData);
            end else begin
                exp = expDataQ.pop_front();
                checkOutput("stream_data", fifoData, exp);
            end
        end
        if (csrPending) begin
            if (csrExpQ.size() == 0) begin
                checksTotal++;
                $display("[TB] FAIL csr_unexpected: got 0x%0h, expected no read", csrReaddata);
            end else begin
                exp = csrExpQ.pop_front();
                a   = csrAddrQ.pop_front();
                checkOutput($sformatf("csr_read[%0d]", a), csrReaddata, exp);
            end
        end else begin
            checkOutput("csr_idle_zero", csrReaddata, 32'd0);
        end
        csrPending = csrRead;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        fifoWrite = 1'b0;
        fifoWdata = '0;
        csrAddr   = '0;
        csrRead   = 1'b0;
        csrWdata  = '0;
        csrWrite  = 1'b0;
        fifoReady = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_waitreq", 32'(waitrequest), 32'd0);
        checkOutput("rst_valid", 32'(fifoValid), 32'd0);
        checkOutput("rst_data", fifoData, 32'd0);
        checkOutput("rst_irq", 32'(irq), 32'd0);
        readCsr(CSR_LEVEL, 32'd0);
        readCsr(CSR_STATUS, 32'hA);
        readCsr(CSR_EVENT, 32'd0);
        readCsr(CSR_IENABLE, 32'd0);
        readCsr(CSR_AF, 32'd14);
        readCsr(CSR_AE, 32'd1);

        $display("[TB] single word pass-through");
        fifoReady = 1'b1;
        checkOutput("t1_waitreq", 32'(waitrequest), 32'd0);
        pushWord(32'hA5);
        checkOutput("t1_valid_next", 32'(fifoValid), 32'd1);
        checkOutput("t1_data_next", fifoData, 32'hA5);
        idle(1);
        readCsr(CSR_LEVEL, 32'd0);
        readCsr(CSR_EVENT, 32'h2);
        writeCsr(CSR_EVENT, 32'hF);

        $display("[TB] fill to full");
        fifoReady = 1'b0;
        for (int i = 0; i < DEPTH; i++) pushWord(32'h100 + 32'(i));
        checkOutput("t2_waitreq_full", 32'(waitrequest), 32'd1);
        checkOutput("t2_head_stable", fifoData, 32'h100);
        applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b0, 3'd0, 32'd0);
        readCsr(CSR_LEVEL, 32'd16);
        readCsr(CSR_STATUS, 32'h5);

        $display("[TB] pop and write at full");
        fifoReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("t5_waitreq[%0d]", i), 32'(waitrequest), 32'(i == 0));
            if (i != 0) expDataQ.push_back(32'h200 + 32'(i));
            applyStimulus(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0, 3'd0, 32'd0);
        end
        fifoReady = 1'b0;
        readCsr(CSR_LEVEL, 32'd15);

        $display("[TB] empty event and irq");
        writeCsr(CSR_IENABLE, 32'h2);
        writeCsr(CSR_EVENT, 32'hF);
        checkOutput("t3_irq_idle", 32'(irq), 32'd0);
        readCsr(CSR_EVENT, 32'd0);
        fifoReady = 1'b1;
        waitEmpty(40);
        fifoReady = 1'b0;
        idle(2);
        checkOutput("t3_irq_set", 32'(irq), 32'd1);
        readCsr(CSR_EVENT, 32'hA);
        writeCsr(CSR_EVENT, 32'h2);
        checkOutput("t3_irq_clear", 32'(irq), 32'd0);
        readCsr(CSR_EVENT, 32'h8);

        $display("[TB] almost-full threshold");
        writeCsr(CSR_AF, 32'd4);
        for (int i = 0; i < 3; i++) pushWord(32'h300 + 32'(i));
        readCsr(CSR_STATUS, 32'h0);
        pushWord(32'h303);
        readCsr(CSR_STATUS, 32'h4);
        writeCsr(CSR_AF, 32'h1F);
        readCsr(CSR_AF, 32'h1F);
        csrAddrQ.push_back(CSR_AF);
        csrExpQ.push_back(32'h1F);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, CSR_AF, 32'd6);
        readCsr(CSR_AF, 32'd6);
        readCsr(CSR_AE, 32'd1);
        fifoReady = 1'b1;
        waitEmpty(20);
        fifoReady = 1'b0;

`ifdef OUTPUT_FIFO_STATS_EN
        $display("[TB] statistics counters");
        for (int i = 0; i < 11; i++) pushWord(32'h400 + 32'(i));
        writeCsr(CSR_WRITES, 32'd0);
        writeCsr(CSR_STALLS, 32'd0);
        for (int i = 11; i < 16; i++) pushWord(32'h400 + 32'(i));
        for (int i = 0; i < 3; i++) begin
            checkOutput("stats_stall_waitreq", 32'(waitrequest), 32'd1);
            applyStimulus(1'b1, 32'hBAD, 1'b0, 1'b0, 3'd0, 32'd0);
        end
        readCsr(CSR_WRITES, 32'd5);
        readCsr(CSR_STALLS, 32'd3);
        writeCsr(CSR_WRITES, 32'd0);
        readCsr(CSR_WRITES, 32'd0);
        readCsr(CSR_STALLS, 32'd3);
        fifoReady = 1'b1;
        waitEmpty(40);
        fifoReady = 1'b0;
`else
        readCsr(CSR_WRITES, 32'd0);
        readCsr(CSR_STALLS, 32'd0);
`endif

        $display("[TB] asynchronous reset mid-operation");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0, 3'd0, 32'd0);
        checkOutput("rst2_valid_before", 32'(fifoValid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst2_valid_async", 32'(fifoValid), 32'd0);
        checkOutput("rst2_data_async", fifoData, 32'd0);
        checkOutput("rst2_irq_async", 32'(irq), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        readCsr(CSR_LEVEL, 32'd0);
        readCsr(CSR_AF, 32'd14);
        readCsr(CSR_EVENT, 32'd0);
        idle(2);

        checkOutput("stream_queue_drained", 32'(expDataQ.size()), 32'd0);
        checkOutput("csr_queue_drained", 32'(csrExpQ.size()), 32'd0);
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
